// File: rtl/dac_frame_receiver.sv
// Serial DAC frame receiver: shifts SYNC_bar-delimited bits MSB first, validates
// 32-bit frames, decodes command fields and keeps frame/error statistics.
module dac_frame_receiver (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        SYNC_bar,
  input  logic        Din,
  output logic [31:0] frame,
  output logic        frame_valid,
  output logic [3:0]  cmd,
  output logic [3:0]  addr,
  output logic [15:0] data,
  output logic [7:0]  pd_state,
  output logic        frame_err,
  output logic [5:0]  bit_count,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {WAIT_HIGH, IDLE, SHIFT, OVER} state_t;

  state_t      state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  bit_count_q, bit_count_d;
  logic [31:0] frame_q, frame_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  pd_q, pd_d;
  logic        fv_q, fv_d;
  logic        fe_q, fe_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [7:0]  ecnt_q, ecnt_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_count_d = bit_count_q;
    frame_d     = frame_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pd_d        = pd_q;
    fv_d        = 1'b0;
    fe_d        = 1'b0;
    fcnt_d      = fcnt_q;
    ecnt_d      = ecnt_q;

    case (state_q)
      WAIT_HIGH: begin
        if (SYNC_bar) state_d = IDLE;
      end
      IDLE: begin
        if (!SYNC_bar) begin
          state_d     = SHIFT;
          bit_count_d = '0;
          if (clk_en) begin
            shift_d     = {shift_q[30:0], Din};
            bit_count_d = 6'd1;
          end
        end
      end
      SHIFT, OVER: begin
        // Frame closes on the SYNC_bar-high edge itself so a one-cycle gap
        // leaves IDLE ready for the next frame's first edge.
        if (SYNC_bar) begin
          state_d     = IDLE;
          bit_count_d = '0;
          if (bit_count_q == 6'd32) begin
            fv_d    = 1'b1;
            frame_d = shift_q;
            cmd_d   = shift_q[27:24];
            addr_d  = shift_q[23:20];
            data_d  = shift_q[19:4];
            if (shift_q[27:24] == 4'b0100) pd_d = shift_q[7:0];
            if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
          end else begin
            fe_d = 1'b1;
            if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
          end
        end else if (clk_en && state_q == SHIFT) begin
          if (bit_count_q == 6'd32) begin
            state_d     = OVER;
            bit_count_d = 6'd33;
          end else begin
            shift_d     = {shift_q[30:0], Din};
            bit_count_d = bit_count_q + 6'd1;
          end
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_HIGH;
      shift_q     <= '0;
      bit_count_q <= '0;
      frame_q     <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      pd_q        <= '0;
      fv_q        <= 1'b0;
      fe_q        <= 1'b0;
      fcnt_q      <= '0;
      ecnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_count_q <= bit_count_d;
      frame_q     <= frame_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pd_q        <= pd_d;
      fv_q        <= fv_d;
      fe_q        <= fe_d;
      fcnt_q      <= fcnt_d;
      ecnt_q      <= ecnt_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign cmd         = cmd_q;
  assign addr        = addr_q;
  assign data        = data_q;
  assign pd_state    = pd_q;
  assign frame_err   = fe_q;
  assign bit_count   = bit_count_q;
  assign frame_cnt   = fcnt_q;
  assign err_cnt     = ecnt_q;

endmodule

// File: tb/tb_dac_frame_receiver.sv
// Scoreboard bench for dac_frame_receiver: the driver pushes per-frame expectations
// from a frame-level model; a monitor checks each output pulse against them.
module tb_dac_frame_receiver;

  logic        clk = 1'b0;
  logic        reset, clk_en, SYNC_bar, Din;
  logic [31:0] frame;
  logic        frame_valid, frame_err;
  logic [3:0]  cmd, addr;
  logic [15:0] data;
  logic [7:0]  pd_state;
  logic [5:0]  bit_count;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  dac_frame_receiver dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .SYNC_bar(SYNC_bar), .Din(Din),
    .frame(frame), .frame_valid(frame_valid), .cmd(cmd), .addr(addr), .data(data),
    .pd_state(pd_state), .frame_err(frame_err), .bit_count(bit_count),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] frame;
    logic [7:0]  pd;
    int          fcnt;
    int          ecnt;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] m_frame = '0;
  logic [7:0]  m_pd = '0;
  int          m_fcnt = 0;
  int          m_ecnt = 0;
  logic        alt = 1'b0;
  logic        prev_pulse = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Frame-level model: only the number of qualified bits and their values matter.
  function automatic void push_expected(input int n, input logic [63:0] val);
    exp_t e;
    if (n == 32) begin
      m_frame = val[31:0];
      if (m_fcnt < 65535) m_fcnt++;
      if (val[27:24] == 4'b0100) m_pd = val[7:0];
    end else begin
      if (m_ecnt < 255) m_ecnt++;
    end
    e.valid = (n == 32);
    e.frame = m_frame;
    e.pd    = m_pd;
    e.fcnt  = m_fcnt;
    e.ecnt  = m_ecnt;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (frame_valid || frame_err)) begin
      chk("pulse_exclusive", 32'(frame_valid && frame_err), 32'd0);
      chk("pulse_width", 32'(prev_pulse), 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("frame_valid", 32'(frame_valid), 32'(e.valid));
        chk("frame_err", 32'(frame_err), 32'(!e.valid));
        chk("frame", frame, e.frame);
        chk("cmd", 32'(cmd), 32'(e.frame[27:24]));
        chk("addr", 32'(addr), 32'(e.frame[23:20]));
        chk("data", 32'(data), 32'(e.frame[19:4]));
        chk("pd_state", 32'(pd_state), 32'(e.pd));
        chk("frame_cnt", 32'(frame_cnt), 32'(e.fcnt));
        chk("err_cnt", 32'(err_cnt), 32'(e.ecnt));
      end
    end
    prev_pulse = !reset && (frame_valid || frame_err);
  end

  // mode 0: clk_en always, 1: alternate cycles, 2: random
  task automatic drive_bit(input logic b, input int mode);
    logic en;
    do begin
      case (mode)
        0:       en = 1'b1;
        1:       begin en = alt; alt = ~alt; end
        default: en = ($urandom_range(0, 2) != 0);
      endcase
      SYNC_bar = 1'b0;
      clk_en   = en;
      Din      = en ? b : 1'($urandom);
      @(negedge clk);
    end while (!en);
  endtask

  task automatic gap(input int n, input logic en_first);
    for (int i = 0; i < n; i++) begin
      SYNC_bar = 1'b1;
      clk_en   = (i == 0 && en_first) ? 1'b1 : 1'($urandom);
      Din      = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input int n, input logic [63:0] val, input int mode,
                            input int gap_n, input logic en_first);
    if (n == 0) begin
      SYNC_bar = 1'b0;
      clk_en   = 1'b0;
      Din      = 1'($urandom);
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) drive_bit(val[n-1-i], mode);
    chk("bit_count", 32'(bit_count), (n > 33) ? 32'd33 : 32'(n));
    push_expected(n, val);
    gap(gap_n, en_first);
  endtask

  task automatic check_reset_state();
    chk("rst_frame", frame, 32'd0);
    chk("rst_fields", {cmd, addr, data, pd_state}, 32'd0);
    chk("rst_pulses", {30'd0, frame_valid, frame_err}, 32'd0);
    chk("rst_bit_count", 32'(bit_count), 32'd0);
    chk("rst_counts", {frame_cnt, err_cnt, 8'd0}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] v;
    int n;
    reset = 1'b1; SYNC_bar = 1'b0; clk_en = 1'b1; Din = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state();

    // SYNC_bar low across reset release must not open a frame
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Din = 1'($urandom);
      @(negedge clk);
    end
    chk("wait_high_bit_count", 32'(bit_count), 32'd0);
    chk("wait_high_quiet", {30'd0, frame_valid, frame_err}, 32'd0);
    gap(1, 1'b0);
    send_frame(32, 64'h04000055, 0, 2, 1'b0);

    send_frame(32, 64'h040003FF, 1, 2, 1'b0);
    send_frame(32, 64'h090C0000, 0, 1, 1'b0);
    send_frame(32, 64'h040003FF, 0, 1, 1'b1);
    send_frame(31, 64'h12345678, 2, 1, 1'b0);
    send_frame(34, 64'h3_5555AAAA, 0, 1, 1'b1);
    send_frame(0, 64'h0, 0, 1, 1'b0);
    send_frame(33, 64'h1_04000011, 1, 2, 1'b0);
    repeat (3) @(negedge clk);

    // Abort a frame half way with reset
    for (int i = 0; i < 16; i++) drive_bit(1'($urandom), 0);
    chk("partial_bit_count", 32'(bit_count), 32'd16);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state();
    m_frame = '0; m_pd = '0; m_fcnt = 0; m_ecnt = 0;
    reset = 1'b0;
    gap(1, 1'b0);
    send_frame(32, 64'h04000033, 2, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);

    // Drive err_cnt into saturation
    for (int i = 0; i < 260; i++) send_frame($urandom_range(0, 4), 64'($urandom), 0, 1, 1'b0);

    for (int i = 0; i < 120; i++) begin
      v = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) v[27:24] = 4'b0100;
      n = ($urandom_range(0, 9) < 7) ? 32 : $urandom_range(0, 36);
      send_frame(n, v, $urandom_range(0, 2), $urandom_range(1, 3), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_err_cnt", 32'(err_cnt), 32'(m_ecnt));
    chk("final_frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_frame_receiver.md
DAC_FRAME_RECEIVER -- requirements
Module: dac_frame_receiver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL clear immediately on reset assertion, independent of clk.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  system clock; all sampling on rising edge.
- reset  in  1  async active-high reset.
- clk_en  in  1  bit-slot qualifier; a bit is sampled only on cycles with clk_en=1.
- SYNC_bar  in  1  frame strobe, active low, synchronous to clk.
- Din  in  1  serial data, MSB first.
- frame  out  32  last complete frame received.
- frame_valid  out  1  one-cycle pulse when frame, cmd, addr and data update.
- cmd  out  4  frame[27:24] of last valid frame.
- addr  out  4  frame[23:20] of last valid frame.
- data  out  16  frame[19:4] of last valid frame.
- pd_state  out  8  power-down mask, frame[7:0] of the last valid frame with cmd=4'b0100.
- frame_err  out  1  one-cycle pulse when a frame ends with a bit count other than 32.
- bit_count  out  6  bits sampled in the current frame, saturating at 33.
- frame_cnt  out  16  count of valid frames, saturating at 16'hFFFF.
- err_cnt  out  8  count of errored frames, saturating at 8'hFF.

Function
REQ-003 FSM states SHALL be WAIT_HIGH, IDLE, SHIFT and OVER.
REQ-004 WAIT_HIGH SHALL be entered on reset and SHALL move to IDLE on the first clk edge that samples SYNC_bar=1; a low SYNC_bar present at reset release SHALL NOT start a frame.
REQ-005 IDLE -> SHIFT SHALL occur on the edge sampling SYNC_bar=0; that edge SHALL also sample Din if clk_en=1.
REQ-006 In SHIFT, each edge with SYNC_bar=0 and clk_en=1 SHALL shift Din into bit 0 of a 32-bit shift register (left shift) and increment bit_count.
REQ-007 A sample that would make bit_count 33 SHALL move the FSM to OVER; bit_count SHALL hold at 33, and further bits SHALL be ignored with the shift register unchanged.
REQ-008 End of frame SHALL be the first edge sampling SYNC_bar=1 while in SHIFT or OVER; no Din sample SHALL be taken on that edge, even if clk_en=1.
REQ-009 At end of frame with bit_count=32, the block SHALL, on the following edge:
- load frame, cmd, addr and data;
- pulse frame_valid for exactly one cycle;
- increment frame_cnt (saturating);
- update pd_state if cmd=4'b0100.
REQ-010 At end of frame with bit_count not equal to 32 (including 0 and 33), the block SHALL, on the following edge:
- pulse frame_err for one cycle;
- increment err_cnt (saturating);
- leave frame, cmd, addr, data and pd_state unchanged.
REQ-011 After end of frame, the FSM SHALL return to IDLE and bit_count SHALL clear to 0 on the same edge that issues frame_valid/frame_err.
REQ-012 frame_valid and frame_err SHALL be mutually exclusive and SHALL never be asserted for more than one consecutive cycle.
REQ-013 A SYNC_bar high pulse of exactly one cycle between frames SHALL be sufficient to delimit them; the next frame SHALL be received without loss.
REQ-014 Cycles with clk_en=0 SHALL neither sample nor alter bit_count, but SYNC_bar edges SHALL still be detected on every clk edge.
REQ-015 Output latency from the SYNC_bar-high sample to the frame_valid/frame_err pulse SHALL be exactly one clk cycle.

Reset
REQ-016 On reset the block SHALL force:
- state = WAIT_HIGH;
- shift register, bit_count and frame = 0;
- cmd, addr and data = 0;
- pd_state = 8'h00;
- frame_valid = 0 and frame_err = 0;
- frame_cnt and err_cnt = 0.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame with no frame_valid or frame_err pulse.

Verification
REQ-018 Frame 32'h040003FF, clk_en every other cycle -> frame_valid 1 cycle; cmd=4'h4, addr=4'h0, data=16'h003F, pd_state=8'hFF, frame_cnt=1.
REQ-019 Frame 32'h090C0000 followed by 32'h040003FF with a 1-cycle SYNC_bar high gap -> two frame_valid pulses; cmd=4'h9 and data=16'hC000 after the first; pd_state=8'hFF after the second; frame_cnt=2.
REQ-020 31-bit frame, then 34-bit frame -> two frame_err pulses; err_cnt=2; frame, cmd, addr, data and pd_state unchanged.
REQ-021 SYNC_bar held low through reset release, then high one cycle, then valid frame 32'h04000055 -> no activity before the high sample; then frame_valid and pd_state=8'h55.
REQ-022 Reset asserted after 16 bits of a frame, then a full valid frame -> no pulse from the partial frame; exactly one frame_valid; frame_cnt=1.
REQ-023 SYNC_bar rises on a cycle with clk_en=1 after 32 samples -> that Din value is not sampled; frame_valid asserted with the 32 prior bits.
